// File: rtl/status_unit_pkg.sv
// Shared NZCV definitions: condition-field encodings and status bit positions.
// Used by status_unit (producer) and the decode-stage condition checker (consumer).
package status_unit_pkg;

    typedef logic [3:0] cond_t;
    typedef logic [3:0] nzcv_t;     // packed {Z,C,N,V}

    localparam cond_t COND_EQ = 4'b0000;
    localparam cond_t COND_NE = 4'b0001;
    localparam cond_t COND_CS = 4'b0010;
    localparam cond_t COND_CC = 4'b0011;
    localparam cond_t COND_MI = 4'b0100;
    localparam cond_t COND_PL = 4'b0101;
    localparam cond_t COND_VS = 4'b0110;
    localparam cond_t COND_VC = 4'b0111;
    localparam cond_t COND_HI = 4'b1000;
    localparam cond_t COND_LS = 4'b1001;
    localparam cond_t COND_GE = 4'b1010;
    localparam cond_t COND_LT = 4'b1011;
    localparam cond_t COND_GT = 4'b1100;
    localparam cond_t COND_LE = 4'b1101;
    localparam cond_t COND_AL = 4'b1110;
    localparam cond_t COND_NV = 4'b1111;

    localparam logic [1:0] ST_Z = 2'd3;
    localparam logic [1:0] ST_C = 2'd2;
    localparam logic [1:0] ST_N = 2'd1;
    localparam logic [1:0] ST_V = 2'd0;

    // AL and NV are unconditional and never depend on the flags.
    function automatic logic cond_reads_flags(input cond_t cond);
        return cond <= COND_LE;
    endfunction

endpackage

// File: rtl/status_unit_flag_gen.sv
// flag_gen: combinational NZCV computation from an execute-stage ALU result.
module flag_gen
    import status_unit_pkg::*;
(
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_logic,
    input  logic        shifter_carry,
    input  logic        v_cur,
    output nzcv_t       flags
);

    always_comb begin
        flags       = '0;
        flags[ST_Z] = (alu_result == 32'd0);
        flags[ST_N] = alu_result[31];
        // Logical ops take C from the shifter and leave V untouched.
        flags[ST_C] = alu_logic ? shifter_carry : alu_carry;
        flags[ST_V] = alu_logic ? v_cur : alu_overflow;
    end

endmodule

// File: rtl/status_unit.sv
// status_unit: architectural NZCV register, in-flight flag-writer counter and decode hazard.
// Optional exception shadow register enabled by defining STATUS_SHADOW_EN.
module status_unit
    import status_unit_pkg::*;
#(
    parameter int unsigned PEND_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_s,
    input  logic [3:0]        cond_id,
    input  logic              exe_s_valid,
    input  logic [31:0]       alu_result,
    input  logic              alu_carry,
    input  logic              alu_overflow,
    input  logic              alu_logic,
    input  logic              shifter_carry,
    input  logic              flush,
    input  logic              exc_entry,
    input  logic              exc_return,
    output logic [3:0]        status,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              pend_full,
    output logic              flag_hazard
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    nzcv_t             status_q, status_d;
    nzcv_t             flags;
    nzcv_t             shadow_q;
    logic [PEND_W-1:0] cnt_q, cnt_d;
    logic              restore;

    flag_gen u_flag_gen (
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .alu_overflow  (alu_overflow),
        .alu_logic     (alu_logic),
        .shifter_carry (shifter_carry),
        .v_cur         (status_q[ST_V]),
        .flags         (flags)
    );

`ifdef STATUS_SHADOW_EN
    nzcv_t shadow_d;

    assign restore = exc_return;

    // Entry samples the pre-write status even when a flag write lands on the same edge.
    always_comb begin
        shadow_d = shadow_q;
        if (exc_entry && !exc_return) begin
            shadow_d = status_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    logic unused_exc;

    assign restore    = 1'b0;
    assign shadow_q   = '0;
    assign unused_exc = exc_entry ^ exc_return;
`endif

    always_comb begin
        status_d = status_q;
        if (restore) begin
            status_d = shadow_q;
        end else if (exe_s_valid) begin
            status_d = flags;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (flush || restore) begin
            cnt_d = '0;
        end else if (issue_s && !exe_s_valid) begin
            if (cnt_q != PEND_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (exe_s_valid && !issue_s) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
            cnt_q    <= '0;
        end else begin
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    assign status      = status_q;
    assign pend_cnt    = cnt_q;
    assign pend_full   = (cnt_q == PEND_MAX);
    assign flag_hazard = (cnt_q != '0) && cond_reads_flags(cond_id);

`ifndef SYNTHESIS
    // A new writer issued while full with nothing retiring would be lost.
    pend_overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
        !(issue_s && pend_full && !exe_s_valid && !flush && !restore))
        else $error("status_unit: issue_s asserted while pend_full");
`endif

endmodule

// File: tb/tb_status_unit.sv
// Scoreboard bench for status_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_status_unit;
    import status_unit_pkg::*;

    localparam int unsigned PEND_W = 2;
    localparam int          MAXC   = (1 << PEND_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              issue_s, exe_s_valid, alu_carry, alu_overflow, alu_logic;
    logic              shifter_carry, flush, exc_entry, exc_return;
    logic [3:0]        cond_id;
    logic [31:0]       alu_result;
    logic [3:0]        status;
    logic [PEND_W-1:0] pend_cnt;
    logic              pend_full, flag_hazard;

    status_unit #(.PEND_W(PEND_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_s       (issue_s),
        .cond_id       (cond_id),
        .exe_s_valid   (exe_s_valid),
        .alu_result    (alu_result),
        .alu_carry     (alu_carry),
        .alu_overflow  (alu_overflow),
        .alu_logic     (alu_logic),
        .shifter_carry (shifter_carry),
        .flush         (flush),
        .exc_entry     (exc_entry),
        .exc_return    (exc_return),
        .status        (status),
        .pend_cnt      (pend_cnt),
        .pend_full     (pend_full),
        .flag_hazard   (flag_hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        int         cnt;
        logic       full;
        logic       hazard;
    } exp_t;

    exp_t       sb[$];
    int         tests_run = 0;
    int         failed    = 0;

    // Reference model state: architectural flags, shadow copy, writers in flight.
    logic [3:0] m_status;
    logic [3:0] m_shadow;
    int         m_cnt;

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: DUT outputs are sampled mid-cycle and matched against queued expectations.
    exp_t e_mon;
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e_mon = sb.pop_front();
                check("status", int'(status), int'(e_mon.st));
                check("pend_cnt", int'(pend_cnt), e_mon.cnt);
                check("pend_full", int'(pend_full), int'(e_mon.full));
                check("flag_hazard", int'(flag_hazard), int'(e_mon.hazard));
            end
        end
    end

    task automatic push_expect(input logic [3:0] cd);
        exp_t e;
        e.st     = m_status;
        e.cnt    = m_cnt;
        e.full   = (m_cnt == MAXC);
        e.hazard = (m_cnt != 0) && (cd != 4'b1110) && (cd != 4'b1111);
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_status = 4'b0000;
        m_shadow = 4'b0000;
        m_cnt    = 0;
    endtask

    // One clock of stimulus; the expectation pushed describes what the DUT shows this cycle.
    task automatic cycle(input logic is, input logic [3:0] cd, input logic ex,
                         input logic [31:0] res, input logic cy, input logic ov,
                         input logic lg, input logic sc, input logic fl,
                         input logic en, input logic rt);
        logic [3:0] f, ns, nsh;
        int         nc;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        issue_s = is; cond_id = cd; exe_s_valid = ex; alu_result = res;
        alu_carry = cy; alu_overflow = ov; alu_logic = lg; shifter_carry = sc;
        flush = fl; exc_entry = en; exc_return = rt;
        push_expect(cd);

        f   = {res == 32'd0, lg ? sc : cy, res[31], lg ? m_status[0] : ov};
        ns  = m_status;
        nsh = m_shadow;
`ifdef STATUS_SHADOW_EN
        if (rt) ns = m_shadow;
        else if (ex) ns = f;
        if (en && !rt) nsh = m_status;
`else
        if (ex) ns = f;
`endif
        nc = m_cnt + (is ? 1 : 0) - (ex ? 1 : 0);
        if (nc < 0) nc = 0;
        if (nc > MAXC) nc = MAXC;
        if (fl) nc = 0;
`ifdef STATUS_SHADOW_EN
        if (rt) nc = 0;
`endif
        m_status = ns;
        m_shadow = nsh;
        m_cnt    = nc;
    endtask

    task automatic idle(input logic [3:0] cd);
        cycle(0, cd, 0, 32'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic arith(input logic is, input logic [31:0] res, input logic cy, input logic ov);
        cycle(is, 4'b1110, 1, res, cy, ov, 0, 0, 0, 0, 0);
    endtask

    task automatic issue(input logic [3:0] cd);
        cycle(1, cd, 0, 32'd0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic        r_is, r_ex, r_fl, r_en, r_rt, r_lg;
        logic [31:0] r_res;
        rst_n = 1'b0;
        issue_s = 0; cond_id = 4'd0; exe_s_valid = 0; alu_result = 32'd0;
        alu_carry = 0; alu_overflow = 0; alu_logic = 0; shifter_carry = 0;
        flush = 0; exc_entry = 0; exc_return = 0;
        model_reset();
        @(posedge clk);
        #2;
        push_expect(4'b0000);

        // Arithmetic write of zero with carry: Z and C set.
        arith(0, 32'd0, 1, 0);
        // Positive nonzero with overflow, then logical negative result keeps V.
        arith(0, 32'd1, 0, 1);
        cycle(0, 4'b1110, 1, 32'h8000_0000, 1, 0, 1, 0, 0, 0, 0);
        idle(4'b0000);

        // Fill the counter, then issue+retire at full.
        issue(4'b1110);
        issue(4'b1110);
        issue(4'b1110);
        arith(1, 32'h0000_1234, 0, 0);
        idle(4'b0101);
        arith(0, 32'hffff_ffff, 1, 1);
        arith(0, 32'h7000_0000, 0, 0);
        arith(0, 32'h0000_0000, 0, 0);
        idle(4'b0000);

        // Hazard depends on condition field and clears once the writer retires.
        issue(4'b1110);
        idle(4'b0000);
        idle(4'b1110);
        idle(4'b1111);
        idle(4'b1101);
        cycle(0, 4'b0000, 1, 32'd5, 0, 0, 0, 0, 0, 0, 0);
        idle(4'b0000);

        // Flush with a simultaneous issue and flag write.
        issue(4'b1110);
        issue(4'b1110);
        cycle(1, 4'b0011, 1, 32'd1, 0, 0, 0, 0, 1, 0, 0);
        idle(4'b0011);

        // Exception entry/return around a flag write.
        arith(0, 32'd0, 1, 0);
        cycle(0, 4'b1110, 0, 32'd0, 0, 0, 0, 0, 0, 1, 0);
        arith(0, 32'd7, 1, 0);
        cycle(0, 4'b1110, 0, 32'd0, 0, 0, 0, 0, 0, 0, 1);
        idle(4'b0000);

        // Entry coincident with a write captures the pre-write flags.
        issue(4'b1110);
        cycle(0, 4'b1110, 1, 32'h8000_0000, 0, 1, 0, 0, 0, 1, 0);
        arith(0, 32'd3, 0, 0);
        cycle(0, 4'b0000, 0, 32'd0, 0, 0, 0, 0, 0, 0, 1);
        idle(4'b0000);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            r_ex  = ($urandom_range(0, 2) == 0);
            r_fl  = ($urandom_range(0, 15) == 0);
            r_en  = ($urandom_range(0, 19) == 0);
            r_rt  = ($urandom_range(0, 19) == 0);
            r_lg  = $urandom_range(0, 1) == 1;
            r_is  = $urandom_range(0, 1) == 1;
            if (m_cnt == MAXC && !r_ex && !r_fl) r_is = 0;
            r_res = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            cycle(r_is, 4'($urandom_range(0, 15)), r_ex, r_res,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, r_lg,
                  $urandom_range(0, 1) == 1, r_fl, r_en, r_rt);
            // Occasional asynchronous reset mid-cycle, observed before the next edge.
            if (i == 300) begin
                issue(4'b1110);
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                issue_s = 0; exe_s_valid = 0; flush = 0; exc_entry = 0; exc_return = 0;
                cond_id = 4'b0000;
                model_reset();
                push_expect(4'b0000);
            end
        end

        idle(4'b0000);
        repeat (3) @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
